// File: rtl/soc_simple_de1_soc_pio.sv
// soc_simple_de1_soc_pio: Avalon-MM general-purpose I/O controller for the DE1-SoC.
// Output data register with atomic set/clear, per-bit direction, synchronised input.
// Define PIO_EDGE_IRQ_EN to add edge capture, the interrupt mask and the level irq;
// without it those registers read 0, ignore writes, and irq is tied low.
module soc_simple_de1_soc_pio #(
    parameter int unsigned WIDTH       = 10,
    parameter logic [31:0] RESET_VALUE = 32'd0,
    parameter int unsigned EDGE_TYPE   = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic             read_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_DIR      = 3'd1;
    localparam logic [2:0] ADDR_MASK     = 3'd2;
    localparam logic [2:0] ADDR_CAPTURE  = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
    localparam logic [2:0] ADDR_INPUT    = 3'd6;

    logic             wrEn;
    logic             rdEn;
    logic [WIDTH-1:0] wrData;
    logic             unusedBits;

    logic [WIDTH-1:0] outData_q, outData_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [31:0]      readValue;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  syncIn;

    assign wrEn       = chipselect & ~write_n;
    assign rdEn       = chipselect & ~read_n;
    assign wrData     = writedata[WIDTH-1:0];
    assign unusedBits = ^writedata;

    // Output data and direction updates: plain writes plus atomic set/clear of data bits
    always_comb begin
        outData_d = outData_q;
        dir_d     = dir_q;
        if (wrEn) begin
            case (address)
                ADDR_DATA:     outData_d = wrData;
                ADDR_DIR:      dir_d     = wrData;
                ADDR_OUTSET:   outData_d = outData_q | wrData;
                ADDR_OUTCLEAR: outData_d = outData_q & ~wrData;
                default:       ;
            endcase
        end
    end

    // Input shift chain; index 0 takes the raw pins, the last stage is the settled value
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
        end
    end

    assign syncIn = sync_q[SYNC_STAGES-1];

`ifdef PIO_EDGE_IRQ_EN
    localparam logic [2:0] SETTLE_CYCLES = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] capture_q, capture_d;
    logic [WIDTH-1:0] edgeHit;
    logic [WIDTH-1:0] clearBits;
    logic [2:0]       settle_q, settle_d;

    // Edge detection, capture set/clear (set wins) and mask writes; edges are ignored while
    // the synchroniser and prev flops still hold post-reset zeros rather than real pin values
    always_comb begin
        if (EDGE_TYPE == 0) begin
            edgeHit = syncIn & ~prev_q;
        end else if (EDGE_TYPE == 1) begin
            edgeHit = ~syncIn & prev_q;
        end else begin
            edgeHit = syncIn ^ prev_q;
        end
        if (settle_q != 3'd0) begin
            edgeHit = '0;
        end
        clearBits = (wrEn && address == ADDR_CAPTURE) ? wrData : '0;
        capture_d = (capture_q & ~clearBits) | edgeHit;
        mask_d    = (wrEn && address == ADDR_MASK) ? wrData : mask_q;
        settle_d  = (settle_q != 3'd0) ? settle_q - 3'd1 : settle_q;
    end

    // Edge-capture state: previous settled input, mask, captured edges, post-reset settle count
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q    <= '0;
            mask_q    <= '0;
            capture_q <= '0;
            settle_q  <= SETTLE_CYCLES;
        end else begin
            prev_q    <= syncIn;
            mask_q    <= mask_d;
            capture_q <= capture_d;
            settle_q  <= settle_d;
        end
    end

    assign irq = |(capture_q & mask_q);
`else
    assign irq = 1'b0;
`endif

    // Read mux over the current (pre-write) register values; unmapped bits and addresses read 0
    always_comb begin
        readValue = '0;
        case (address)
            ADDR_DATA:    readValue[WIDTH-1:0] = outData_q;
            ADDR_DIR:     readValue[WIDTH-1:0] = dir_q;
`ifdef PIO_EDGE_IRQ_EN
            ADDR_MASK:    readValue[WIDTH-1:0] = mask_q;
            ADDR_CAPTURE: readValue[WIDTH-1:0] = capture_q;
`endif
            ADDR_INPUT:   readValue[WIDTH-1:0] = syncIn;
            default:      ;
        endcase
        readdata_d = rdEn ? readValue : readdata_q;
    end

    // Register state: data, direction and the held read result
    always_ff @(posedge clk) begin
        if (reset) begin
            outData_q  <= RESET_VALUE[WIDTH-1:0];
            dir_q      <= '0;
            readdata_q <= '0;
        end else begin
            outData_q  <= outData_d;
            dir_q      <= dir_d;
            readdata_q <= readdata_d;
        end
    end

    assign out_port = outData_q;
    assign oe       = dir_q;
    assign readdata = readdata_q;

endmodule

// File: tb/tb_soc_simple_de1_soc_pio.sv
// tb_soc_simple_de1_soc_pio: two PIO instances (rising edge / 2 stages and any edge / 3 stages)
// sharing one bus, checked against a pin-history reference model; honours PIO_EDGE_IRQ_EN.
module tb_soc_simple_de1_soc_pio;

    localparam int          W  = 10;
    localparam logic [31:0] RV = 32'h2A5;
    localparam int          SA = 2;
    localparam int          SB = 3;
`ifdef PIO_EDGE_IRQ_EN
    localparam bit HAS_EDGE = 1'b1;
`else
    localparam bit HAS_EDGE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   address;
    logic         chipselect;
    logic         write_n;
    logic         read_n;
    logic [31:0]  writedata;
    logic [W-1:0] pins;

    logic [31:0]  rdA, rdB;
    logic [W-1:0] outA, oeA, outB, oeB;
    logic         irqA, irqB;

    // Reference model state: registers, expected read results and post-reset pin samples
    logic [W-1:0] mOut, mDir, mMask, mCapA, mCapB;
    logic [31:0]  mReadA, mReadB;
    logic [W-1:0] samp[$];

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        cs;
        logic        wrN;
        logic        rdN;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [9:0]  expOut;
        logic [9:0]  expOe;
        logic [31:0] expRd;
    } vec_t;

    vec_t tbl [13];

    always #5 clk = ~clk;

    soc_simple_de1_soc_pio #(.WIDTH(W), .RESET_VALUE(RV), .EDGE_TYPE(0), .SYNC_STAGES(SA)) dutA (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(rdA),
        .in_port(pins), .out_port(outA), .oe(oeA), .irq(irqA)
    );

    soc_simple_de1_soc_pio #(.WIDTH(W), .RESET_VALUE(RV), .EDGE_TYPE(2), .SYNC_STAGES(SB)) dutB (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(rdB),
        .in_port(pins), .out_port(outB), .oe(oeB), .irq(irqB)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [2:0] a, input logic [W-1:0] inVal,
                                              input logic [W-1:0] cap);
        logic [31:0] r;
        r = '0;
        case (a)
            3'd0: r[W-1:0] = mOut;
            3'd1: r[W-1:0] = mDir;
            3'd2: r[W-1:0] = HAS_EDGE ? mMask : '0;
            3'd3: r[W-1:0] = HAS_EDGE ? cap : '0;
            3'd6: r[W-1:0] = inVal;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Advance the model by one clock edge. A pin sampled at post-reset edge j is visible
    // on INPUT after edge j+S-1; a change between samples j-1 and j is captured at edge j+S.
    task automatic stepModel();
        int k;
        logic [W-1:0] inA, inB, edgeA, edgeB, wd, clr;
        if (reset) begin
            mOut = RV[W-1:0]; mDir = '0; mMask = '0; mCapA = '0; mCapB = '0;
            mReadA = '0; mReadB = '0;
            samp.delete();
            return;
        end
        k = samp.size();
        inA = (k >= SA) ? samp[k-SA] : '0;
        inB = (k >= SB) ? samp[k-SB] : '0;
        if (chipselect && !read_n) begin
            mReadA = modelRead(address, inA, mCapA);
            mReadB = modelRead(address, inB, mCapB);
        end
        samp.push_back(pins);
        k = samp.size();
        edgeA = '0;
        edgeB = '0;
        if (k >= SA + 2) edgeA = samp[k-SA-1] & ~samp[k-SA-2];
        if (k >= SB + 2) edgeB = samp[k-SB-1] ^ samp[k-SB-2];
        wd  = writedata[W-1:0];
        clr = '0;
        if (chipselect && !write_n) begin
            case (address)
                3'd0: mOut = wd;
                3'd1: mDir = wd;
                3'd2: mMask = wd;
                3'd3: clr = wd;
                3'd4: mOut = mOut | wd;
                3'd5: mOut = mOut & ~wd;
                default: ;
            endcase
        end
        mCapA = (mCapA & ~clr) | edgeA;
        mCapB = (mCapB & ~clr) | edgeB;
    endtask

    task automatic applyStimulus(input logic cs, input logic wrN, input logic rdN,
                                 input logic [2:0] a, input logic [31:0] d);
        chipselect = cs;
        write_n    = wrN;
        read_n     = rdN;
        address    = a;
        writedata  = d;
        stepModel();
        @(posedge clk);
        #1;
        checkOutput("outA", 32'(outA), 32'(mOut));
        checkOutput("oeA", 32'(oeA), 32'(mDir));
        checkOutput("rdA", rdA, mReadA);
        checkOutput("irqA", 32'(irqA), 32'(HAS_EDGE & (|(mCapA & mMask))));
        checkOutput("outB", 32'(outB), 32'(mOut));
        checkOutput("oeB", 32'(oeB), 32'(mDir));
        checkOutput("rdB", rdB, mReadB);
        checkOutput("irqB", 32'(irqB), 32'(HAS_EDGE & (|(mCapB & mMask))));
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b1, 1'b1, 3'd0, 32'h0);
    endtask

    task automatic writeReg(input logic [2:0] a, input logic [31:0] d);
        applyStimulus(1'b1, 1'b0, 1'b1, a, d);
    endtask

    task automatic readReg(input logic [2:0] a);
        applyStimulus(1'b1, 1'b1, 1'b0, a, 32'h0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_0000, 10'h2A5, 10'h000, 32'h0000_02A5};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 3'd0, 32'hFFFF_F0F0, 10'h0F0, 10'h000, 32'h0000_02A5};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 3'd4, 32'h0000_000F, 10'h0FF, 10'h000, 32'h0000_02A5};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 3'd5, 32'h0000_00F0, 10'h00F, 10'h000, 32'h0000_02A5};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_0000, 10'h00F, 10'h000, 32'h0000_000F};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 3'd7, 32'hFFFF_FFFF, 10'h00F, 10'h000, 32'h0000_000F};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 3'd1, 32'h0000_03C3, 10'h00F, 10'h3C3, 32'h0000_0000};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 3'd1, 32'h0000_0000, 10'h00F, 10'h3C3, 32'h0000_03C3};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 3'd4, 32'h0000_0000, 10'h00F, 10'h3C3, 32'h0000_0000};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 3'd0, 32'h0000_0155, 10'h00F, 10'h3C3, 32'h0000_0000};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 3'd7, 32'h0000_0000, 10'h00F, 10'h3C3, 32'h0000_0000};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 3'd6, 32'h0000_0000, 10'h00F, 10'h3C3, 32'h0000_0000};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 3'd0, 32'h0000_0400, 10'h000, 10'h3C3, 32'h0000_0000};

        reset = 1'b1;
        pins  = '0;
        idle();
        idle();
        checkOutput("rst_out", 32'(outA), 32'h2A5);
        checkOutput("rst_oe", 32'(oeA), 32'h0);
        checkOutput("rst_irq", 32'(irqA), 32'h0);
        checkOutput("rst_rd", rdA, 32'h0);
        reset = 1'b0;

        // Register map vectors
        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i].cs, tbl[i].wrN, tbl[i].rdN, tbl[i].addr, tbl[i].wdata);
            checkOutput($sformatf("tbl%0d_out", i), 32'(outA), 32'(tbl[i].expOut));
            checkOutput($sformatf("tbl%0d_oe", i), 32'(oeA), 32'(tbl[i].expOe));
            checkOutput($sformatf("tbl%0d_rd", i), rdA, tbl[i].expRd);
        end

        // Pin-to-INPUT latency, capture with mask 0, then unmask
        pins[3] = 1'b1;
        readReg(3'd6);
        checkOutput("in_lat0", rdA, 32'h0);
        readReg(3'd6);
        checkOutput("in_lat1", rdA, 32'h0);
        readReg(3'd6);
        checkOutput("in_lat2", rdA, 32'h8);
        checkOutput("irq_unmasked", 32'(irqA), 32'h0);
        readReg(3'd3);
        checkOutput("cap_bit3", rdA, HAS_EDGE ? 32'h8 : 32'h0);
        writeReg(3'd2, 32'h0000_0008);
        checkOutput("irq_masked", 32'(irqA), 32'(HAS_EDGE));
        idle();
        idle();
        idle();

        // Clear colliding with a new rising edge on bit 3, then a quiet clear
        pins[3] = 1'b0;
        idle();
        pins[3] = 1'b1;
        idle();
        idle();
        writeReg(3'd3, 32'h8);
        checkOutput("collide_irq", 32'(irqA), 32'(HAS_EDGE));
        readReg(3'd3);
        checkOutput("collide_cap", rdA, HAS_EDGE ? 32'h8 : 32'h0);
        for (int i = 0; i < 4; i++) idle();
        writeReg(3'd3, 32'h8);
        checkOutput("quiet_irqA", 32'(irqA), 32'h0);
        checkOutput("quiet_irqB", 32'(irqB), 32'h0);

        // Pulse on bit 0: any-edge instance captures both edges, rising-only just one
        pins[0] = 1'b1;
        idle();
        idle();
        pins[0] = 1'b0;
        idle();
        idle();
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd3, 32'h1);
        checkOutput("pulse_riseB", 32'(rdB[0]), 32'(HAS_EDGE));
        idle();
        readReg(3'd3);
        checkOutput("pulse_fallB", 32'(rdB[0]), 32'(HAS_EDGE));
        checkOutput("pulse_fallA", 32'(rdA[0]), 32'h0);

        // Reset mid-pulse with pins held static: nothing may be captured afterwards
        pins[0] = 1'b1;
        idle();
        idle();
        reset = 1'b1;
        idle();
        reset = 1'b0;
        checkOutput("midrst_out", 32'(outA), 32'h2A5);
        for (int i = 0; i < 7; i++) begin
            readReg(3'd3);
            checkOutput($sformatf("midrst_capA%0d", i), rdA, 32'h0);
            checkOutput($sformatf("midrst_capB%0d", i), rdB, 32'h0);
        end

        // Mask write-back, then randomized traffic against the model
        writeReg(3'd2, 32'h0000_03FF);
        readReg(3'd2);
        checkOutput("mask_read", rdA, HAS_EDGE ? 32'h3FF : 32'h0);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) pins = pins ^ W'(1 << $urandom_range(0, W - 1));
            reset = ($urandom_range(0, 99) == 0);
            applyStimulus($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                          3'($urandom), $urandom);
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
